// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// State and operand-select encodings are visible on the debug and mux ports.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FREEZE = 2'd2,
        FLUSH  = 2'd3
    } hazard_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand dependency compare: picks the newest in-flight producer of rs.
// Also reports the raw EX-stage hit so the caller can detect load-use.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                      mem_we_i,
    output fwd_sel_e                  sel_o,
    output logic                      ex_hit_o
);

    logic rs_live;
    logic mem_hit;

    // x0 is hard-wired, so it can never carry a dependency
    assign rs_live  = valid_i && (rs_addr_i != REG_ADDR_WIDTH'(REG_ZERO));
    assign ex_hit_o = rs_live && ex_we_i && (rs_addr_i == ex_rd_addr_i);
    assign mem_hit  = rs_live && mem_we_i && (rs_addr_i == mem_rd_addr_i);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit_o) begin
            sel_o = FWD_MEM;
        end else if (mem_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/freeze sequencer and registered EX operand selects.
// Define HAZARD_PERF_CNT_EN to add saturating stall and flush counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned LOAD_LATENCY   = 1,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_reg_we_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                      mem_reg_we_i,
    input  logic                      branch_taken_i,
    input  logic                      mem_busy_i,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      flush_id_o,
    output logic                      bubble_ex_o,
    output logic                      freeze_all_o,
    output logic [1:0]                fwd_a_o,
    output logic [1:0]                fwd_b_o,
    output logic [1:0]                state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      perf_stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      perf_flush_cnt_o
`endif
);

    localparam int unsigned LAT =
        (LOAD_LATENCY < 1) ? 1 : ((LOAD_LATENCY > 3) ? 3 : LOAD_LATENCY);
    localparam logic [1:0] LAT_M1 = 2'(LAT - 1);

    hazard_state_e state_q, state_d;
    hazard_state_e prior_q, prior_d;
    logic          pend_q, pend_d;
    logic [1:0]    cnt_q, cnt_d;
    fwd_sel_e      fwd_a_q, fwd_a_d;
    fwd_sel_e      fwd_b_q, fwd_b_d;
    fwd_sel_e      sel_a, sel_b;
    logic          hit_a, hit_b;
    logic          load_use;
    logic          stall_if, stall_id, flush, bubble, freeze;

    hazard_fwd_sel #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_a (
        .valid_i      (id_valid_i),
        .rs_addr_i    (id_rs1_addr_i),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_we_i      (ex_reg_we_i),
        .mem_rd_addr_i(mem_rd_addr_i),
        .mem_we_i     (mem_reg_we_i),
        .sel_o        (sel_a),
        .ex_hit_o     (hit_a)
    );

    hazard_fwd_sel #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_b (
        .valid_i      (id_valid_i),
        .rs_addr_i    (id_rs2_addr_i),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_we_i      (ex_reg_we_i),
        .mem_rd_addr_i(mem_rd_addr_i),
        .mem_we_i     (mem_reg_we_i),
        .sel_o        (sel_b),
        .ex_hit_o     (hit_b)
    );

    assign load_use = ex_is_load_i && (hit_a || hit_b);

    always_comb begin
        state_d  = state_q;
        prior_d  = prior_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush    = 1'b0;
        bubble   = 1'b0;
        freeze   = 1'b0;
        if (mem_busy_i) begin
            // a branch seen while frozen is remembered, not dropped
            freeze  = 1'b1;
            state_d = FREEZE;
            if (state_q != FREEZE) begin
                prior_d = state_q;
            end
            if (branch_taken_i) begin
                pend_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken_i) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                        cnt_d  = 2'd0;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        bubble   = 1'b1;
                        cnt_d    = LAT_M1;
                        state_d  = (LAT > 1) ? LSTALL : RUN;
                    end
                end
                LSTALL: begin
                    if (branch_taken_i) begin
                        flush   = 1'b1;
                        bubble  = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        bubble   = 1'b1;
                        cnt_d    = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                        state_d  = (cnt_q <= 2'd1) ? RUN : LSTALL;
                    end
                end
                FREEZE: begin
                    state_d = pend_q ? FLUSH : prior_q;
                end
                FLUSH: begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (bubble || flush) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end else if (!stall_id && !freeze) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            prior_q <= RUN;
            pend_q  <= 1'b0;
            cnt_q   <= 2'd0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            prior_q <= prior_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // reset must silence the enables at once, not at the next edge
    assign stall_if_o   = stall_if & ~rst_i;
    assign stall_id_o   = stall_id & ~rst_i;
    assign flush_id_o   = flush & ~rst_i;
    assign bubble_ex_o  = bubble & ~rst_i;
    assign freeze_all_o = freeze & ~rst_i;
    assign fwd_a_o      = fwd_a_q;
    assign fwd_b_o      = fwd_b_q;
    assign state_o      = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] pstall_q, pstall_d;
    logic [CNT_WIDTH-1:0] pflush_q, pflush_d;

    always_comb begin
        pstall_d = pstall_q;
        pflush_d = pflush_q;
        if ((stall_id_o || freeze_all_o) && !(&pstall_q)) begin
            pstall_d = pstall_q + CNT_WIDTH'(1);
        end
        if (flush_id_o && !(&pflush_q)) begin
            pflush_d = pflush_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pstall_q <= '0;
            pflush_q <= '0;
        end else begin
            pstall_q <= pstall_d;
            pflush_q <= pflush_d;
        end
    end

    assign perf_stall_cnt_o = pstall_q;
    assign perf_flush_cnt_o = pflush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomised and directed bench for hazard_ctrl_unit at load latencies 1 and 3.
// A mode-based reference model predicts every enable, select and state.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0, exwe = 1'b0, ld = 1'b0, memwe = 1'b0;
    logic br = 1'b0, busy = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, exrd = '0, memrd = '0;

    logic [1:0] s_if, s_id, fl, bb, fz;
    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic [1:0] st [2];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] pc_st [2];
    logic [31:0] pc_fl [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: underlying mode plus a freeze overlay
    int lat [2] = '{1, 3};
    int left [2];
    bit frozen [2];
    bit pend [2];
    bit dflush [2];
    int mfa [2];
    int mfb [2];
    longint mps [2];
    longint mpf [2];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_ADDR_WIDTH(5), .LOAD_LATENCY(1), .CNT_WIDTH(32)
    ) u_lat1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_rd_addr_i(exrd), .ex_reg_we_i(exwe), .ex_is_load_i(ld),
        .mem_rd_addr_i(memrd), .mem_reg_we_i(memwe),
        .branch_taken_i(br), .mem_busy_i(busy),
        .stall_if_o(s_if[0]), .stall_id_o(s_id[0]), .flush_id_o(fl[0]),
        .bubble_ex_o(bb[0]), .freeze_all_o(fz[0]),
        .fwd_a_o(fa[0]), .fwd_b_o(fb[0]), .state_o(st[0])
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt_o(pc_st[0]), .perf_flush_cnt_o(pc_fl[0])
`endif
    );

    hazard_ctrl_unit #(
        .REG_ADDR_WIDTH(5), .LOAD_LATENCY(3), .CNT_WIDTH(32)
    ) u_lat3 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_rd_addr_i(exrd), .ex_reg_we_i(exwe), .ex_is_load_i(ld),
        .mem_rd_addr_i(memrd), .mem_reg_we_i(memwe),
        .branch_taken_i(br), .mem_busy_i(busy),
        .stall_if_o(s_if[1]), .stall_id_o(s_id[1]), .flush_id_o(fl[1]),
        .bubble_ex_o(bb[1]), .freeze_all_o(fz[1]),
        .fwd_a_o(fa[1]), .fwd_b_o(fb[1]), .state_o(st[1])
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt_o(pc_st[1]), .perf_flush_cnt_o(pc_fl[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int ref_sel(input logic [4:0] rs);
        if (!valid || rs == 0) return 0;
        if (exwe && rs == exrd) return 1;
        if (memwe && rs == memrd) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; frozen[i] = 0; pend[i] = 0; dflush[i] = 0;
            mfa[i] = 0; mfb[i] = 0; mps[i] = 0; mpf[i] = 0;
        end
    endtask

    task automatic model_check(input int i);
        bit e_if, e_id, e_fl, e_bb, e_fz, lu;
        int e_st;
        string p;
        p = $sformatf("L%0d.", lat[i]);
        e_if = 0; e_id = 0; e_fl = 0; e_bb = 0; e_fz = 0;
        lu = valid && ld && exwe && exrd != 0 && (exrd == rs1 || exrd == rs2);
        e_st = frozen[i] ? 2 : (dflush[i] ? 3 : ((left[i] > 0) ? 1 : 0));
        check_eq({p, "state"}, st[i], e_st);
        check_eq({p, "fwd_a"}, fa[i], mfa[i]);
        check_eq({p, "fwd_b"}, fb[i], mfb[i]);
`ifdef HAZARD_PERF_CNT_EN
        check_eq({p, "perf_stall"}, pc_st[i], mps[i]);
        check_eq({p, "perf_flush"}, pc_fl[i], mpf[i]);
`endif
        if (busy) begin
            e_fz = 1;
            frozen[i] = 1;
            if (br) pend[i] = 1;
        end else if (frozen[i]) begin
            frozen[i] = 0;
            if (pend[i]) dflush[i] = 1;
        end else if (dflush[i]) begin
            e_fl = 1; e_bb = 1;
            dflush[i] = 0; pend[i] = 0; left[i] = 0;
        end else if (br) begin
            e_fl = 1; e_bb = 1; left[i] = 0;
        end else if (left[i] > 0) begin
            e_if = 1; e_id = 1; e_bb = 1; left[i]--;
        end else if (lu) begin
            e_if = 1; e_id = 1; e_bb = 1; left[i] = lat[i] - 1;
        end
        check_eq({p, "stall_if"}, s_if[i], e_if);
        check_eq({p, "stall_id"}, s_id[i], e_id);
        check_eq({p, "flush_id"}, fl[i], e_fl);
        check_eq({p, "bubble_ex"}, bb[i], e_bb);
        check_eq({p, "freeze_all"}, fz[i], e_fz);
        if (e_bb || e_fl) begin
            mfa[i] = 0; mfb[i] = 0;
        end else if (!e_id && !e_fz) begin
            mfa[i] = ref_sel(rs1); mfb[i] = ref_sel(rs2);
        end
        if (e_id || e_fz) mps[i]++;
        if (e_fl) mpf[i]++;
    endtask

    task automatic step(input bit b_busy, input bit b_br, input bit b_ld,
                        input bit b_exwe, input bit b_memwe, input bit b_val,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] ae, input logic [4:0] am);
        @(negedge clk);
        busy = b_busy; br = b_br; ld = b_ld; exwe = b_exwe;
        memwe = b_memwe; valid = b_val;
        rs1 = a1; rs2 = a2; exrd = ae; memrd = am;
        #1;
        for (int i = 0; i < 2; i++) model_check(i);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic check_in_reset();
        for (int i = 0; i < 2; i++) begin
            check_eq("rst.stall_if", s_if[i], 0);
            check_eq("rst.stall_id", s_id[i], 0);
            check_eq("rst.flush_id", fl[i], 0);
            check_eq("rst.bubble_ex", bb[i], 0);
            check_eq("rst.freeze_all", fz[i], 0);
            check_eq("rst.fwd_a", fa[i], 0);
            check_eq("rst.fwd_b", fb[i], 0);
            check_eq("rst.state", st[i], 0);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        busy = 0; br = 0; ld = 0; exwe = 0; memwe = 0; valid = 0;
        rs1 = 0; rs2 = 0; exrd = 0; memrd = 0;
        rst = 0;
        model_reset();
    endtask

    initial begin
        model_reset();
        // hazard-looking inputs while in reset must not leak out
        valid = 1; ld = 1; exwe = 1; exrd = 5'd5; rs1 = 5'd5;
        @(negedge clk);
        #1;
        check_in_reset();
        release_reset();

        // lw x5 ; add x6,x5,x7
        step(0, 0, 1, 1, 0, 1, 5'd5, 5'd7, 5'd5, 5'd0);
        step(0, 0, 0, 0, 1, 1, 5'd5, 5'd7, 5'd0, 5'd5);
        idle(); idle(); idle();

        // add x3 ; sub x4,x7,x3 with x3 also in MEM
        step(0, 0, 0, 1, 1, 1, 5'd7, 5'd3, 5'd3, 5'd3);
        idle();

        // x0 never creates a dependency
        step(0, 0, 1, 1, 1, 1, 5'd0, 5'd0, 5'd0, 5'd0);
        idle();

        // branch during 3-cycle bus stall, deferred flush
        step(1, 1, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3, 5'd4);
        step(1, 0, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3, 5'd4);
        step(1, 0, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3, 5'd4);
        idle(); idle(); idle();

        // load-use then taken branch in the second bubble
        step(0, 0, 1, 1, 0, 1, 5'd9, 5'd9, 5'd9, 5'd0);
        step(0, 1, 0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 5'd9);
        idle(); idle();

        // freeze in the middle of a long load-use stall
        step(0, 0, 1, 1, 0, 1, 5'd2, 5'd8, 5'd8, 5'd0);
        step(1, 0, 0, 0, 0, 1, 5'd2, 5'd8, 5'd0, 5'd0);
        step(1, 0, 0, 0, 0, 1, 5'd2, 5'd8, 5'd0, 5'd0);
        idle(); idle(); idle(); idle();

        // asynchronous reset while the long stall is running
        step(0, 0, 1, 1, 0, 1, 5'd6, 5'd1, 5'd6, 5'd0);
        step(0, 0, 0, 0, 1, 1, 5'd6, 5'd1, 5'd0, 5'd6);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check_in_reset();
        release_reset();

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 12, $urandom_range(99) < 10,
                 $urandom_range(99) < 35, $urandom_range(99) < 75,
                 $urandom_range(99) < 70, $urandom_range(99) < 85,
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
